// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped L2 cache model.
package cache_pkg;

    localparam int unsigned ADDR_W_DEF  = 11;
    localparam int unsigned DATA_W_DEF  = 11;
    localparam int unsigned INDEX_W_DEF = 6;

    localparam int unsigned TAG_W     = ADDR_W_DEF - INDEX_W_DEF;
    localparam int unsigned NUM_LINES = 1 << INDEX_W_DEF;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DATA_W_DEF-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache: one combinational lookup port and one
// synchronous fill port. Only the valid bits are reset.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_W   = INDEX_W_DEF,
    parameter int unsigned LINE_TAG_W = TAG_W,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    lookup_index_i,
    output logic                  lookup_valid_o,
    output logic [LINE_TAG_W-1:0] lookup_tag_o,
    output logic [DATA_W-1:0]     lookup_data_o,
    input  logic                  fill_en_i,
    input  logic [INDEX_W-1:0]    fill_index_i,
    input  logic [LINE_TAG_W-1:0] fill_tag_i,
    input  logic [DATA_W-1:0]     fill_data_i
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic [LINES-1:0]      valid_q;
    logic [LINE_TAG_W-1:0] tag_q  [LINES];
    logic [DATA_W-1:0]     data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_index_i] <= 1'b1;
        end
    end

    // Tag/data are qualified by valid, so they never need clearing.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_index_i]  <= fill_tag_i;
            data_q[fill_index_i] <= fill_data_i;
        end
    end

    assign lookup_valid_o = valid_q[lookup_index_i];
    assign lookup_tag_o   = tag_q[lookup_index_i];
    assign lookup_data_o  = data_q[lookup_index_i];

endmodule

// File: rtl/cache_direct_l2.sv
// Direct-mapped, read-only L2 cache with one-word lines. Misses fill in the same cycle from a
// synthetic backing store whose word at address A is A itself.
module cache_direct_l2
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] read_data,
    output logic              hit
);

    localparam int unsigned LINE_TAG_W = ADDR_W - INDEX_W;

    logic [INDEX_W-1:0]    req_index;
    logic [LINE_TAG_W-1:0] req_tag;
    logic                  line_valid;
    logic [LINE_TAG_W-1:0] line_tag;
    logic [DATA_W-1:0]     line_data;
    logic [DATA_W-1:0]     fill_word;
    logic                  is_hit;
    logic                  fill_en;
    logic                  hit_q;
    logic [DATA_W-1:0]     read_data_q;

    assign req_index = addr[INDEX_W-1:0];
    assign req_tag   = addr[ADDR_W-1:INDEX_W];
    assign fill_word = DATA_W'(addr);

    assign is_hit  = line_valid && (line_tag == req_tag);
    // Reset wins over a coincident read, which is dropped without a fill.
    assign fill_en = read && !rst && !is_hit;

    cache_line_array #(
        .INDEX_W    (INDEX_W),
        .LINE_TAG_W (LINE_TAG_W),
        .DATA_W     (DATA_W)
    ) u_lines (
        .clk            (clk),
        .rst            (rst),
        .lookup_index_i (req_index),
        .lookup_valid_o (line_valid),
        .lookup_tag_o   (line_tag),
        .lookup_data_o  (line_data),
        .fill_en_i      (fill_en),
        .fill_index_i   (req_index),
        .fill_tag_i     (req_tag),
        .fill_data_i    (fill_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q       <= 1'b0;
            read_data_q <= '0;
        end else if (read) begin
            hit_q       <= is_hit;
            read_data_q <= is_hit ? line_data : fill_word;
        end
    end

    assign hit       = hit_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_cache_direct_l2.sv
// Self-checking bench for cache_direct_l2: scripted scenarios plus a randomized trace
// checked against a resident-address-per-line reference model.
module tb_cache_direct_l2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0;
    logic [10:0] addr = '0;
    logic [10:0] read_data;
    logic        hit;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: which full address currently occupies each of the 64 lines (-1 = empty).
    int resident [64];

    cache_direct_l2 dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .addr      (addr),
        .read_data (read_data),
        .hit       (hit)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 64; i++) resident[i] = -1;
    endtask

    task automatic pulse_reset(input logic with_read, input logic [10:0] a);
        @(negedge clk);
        rst  = 1'b1;
        read = with_read;
        addr = a;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        read = 1'b0;
        model_clear();
    endtask

    // One read; returns what the model says the DUT must report afterwards.
    task automatic access(input logic [10:0] a, output logic eh, output logic [10:0] ed);
        int idx;
        @(negedge clk);
        read = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        read = 1'b0;
        idx = int'(a) % 64;
        eh  = (resident[idx] == int'(a));
        ed  = a;
        if (!eh) resident[idx] = int'(a);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            read = 1'b0;
            addr = 11'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        pulse_reset(1'b0, 11'd0);
        n_vec++;
        if ({hit, read_data} !== {1'b0, 11'h000}) begin
            n_miss++;
            $display("FAIL reset_state: hit=%0b data=%03h, want hit=0 data=000", hit, read_data);
        end
    endtask

    task automatic test_cold_fill();
        logic [10:0] seq [3] = '{11'd50, 11'd60, 11'd70};
        logic [10:0] want [3] = '{11'h032, 11'h03C, 11'h046};
        logic eh;
        logic [10:0] ed;
        for (int i = 0; i < 3; i++) begin
            access(seq[i], eh, ed);
            n_vec++;
            if ({hit, read_data} !== {1'b0, want[i]} || {eh, ed} !== {1'b0, want[i]}) begin
                n_miss++;
                $display("FAIL cold_fill[%0d]: hit=%0b data=%03h, want hit=0 data=%03h",
                         i, hit, read_data, want[i]);
            end
            idle(1);
        end
    endtask

    task automatic test_rereference();
        logic [10:0] seq [4] = '{11'd50, 11'd80, 11'd90, 11'd60};
        logic        wh  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic eh;
        logic [10:0] ed;
        for (int i = 0; i < 4; i++) begin
            access(seq[i], eh, ed);
            n_vec++;
            if ({hit, read_data} !== {wh[i], seq[i]} || eh !== wh[i]) begin
                n_miss++;
                $display("FAIL reref[%0d]: hit=%0b data=%03h, want hit=%0b data=%03h",
                         i, hit, read_data, wh[i], seq[i]);
            end
        end
    endtask

    task automatic test_full_trace();
        logic [10:0] seq [10] = '{11'd50, 11'd60, 11'd70, 11'd50, 11'd80,
                                  11'd90, 11'd60, 11'd100, 11'd110, 11'd50};
        logic        wh  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic eh;
        logic [10:0] ed;
        pulse_reset(1'b0, 11'd0);
        for (int i = 0; i < 10; i++) begin
            access(seq[i], eh, ed);
            n_vec++;
            if ({hit, read_data} !== {wh[i], seq[i]}) begin
                n_miss++;
                $display("FAIL full_trace[%0d] addr=%0d: hit=%0b data=%03h, want hit=%0b data=%03h",
                         i, seq[i], hit, read_data, wh[i], seq[i]);
            end
        end
    endtask

    task automatic test_conflict();
        logic [10:0] seq  [3] = '{11'd50, 11'd114, 11'd50};
        logic [10:0] want [3] = '{11'h032, 11'h072, 11'h032};
        logic eh;
        logic [10:0] ed;
        pulse_reset(1'b0, 11'd0);
        for (int i = 0; i < 3; i++) begin
            access(seq[i], eh, ed);
            n_vec++;
            if ({hit, read_data} !== {1'b0, want[i]}) begin
                n_miss++;
                $display("FAIL conflict[%0d]: hit=%0b data=%03h, want hit=0 data=%03h",
                         i, hit, read_data, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_trace();
        logic eh;
        logic [10:0] ed;
        access(11'd50, eh, ed);
        access(11'd50, eh, ed);
        n_vec++;
        if ({hit, read_data} !== {1'b1, 11'h032}) begin
            n_miss++;
            $display("FAIL pre_reset_hit: hit=%0b data=%03h, want hit=1 data=032", hit, read_data);
        end
        pulse_reset(1'b0, 11'd0);
        n_vec++;
        if ({hit, read_data} !== {1'b0, 11'h000}) begin
            n_miss++;
            $display("FAIL mid_reset: hit=%0b data=%03h, want hit=0 data=000", hit, read_data);
        end
        access(11'd50, eh, ed);
        n_vec++;
        if ({hit, read_data} !== {1'b0, 11'h032}) begin
            n_miss++;
            $display("FAIL post_reset_read: hit=%0b data=%03h, want hit=0 data=032",
                     hit, read_data);
        end
    endtask

    task automatic test_reset_with_read();
        logic eh;
        logic [10:0] ed;
        access(11'd77, eh, ed);
        pulse_reset(1'b1, 11'd77);
        n_vec++;
        if ({hit, read_data} !== {1'b0, 11'h000}) begin
            n_miss++;
            $display("FAIL rst_and_read: hit=%0b data=%03h, want hit=0 data=000", hit, read_data);
        end
        idle(1);
        access(11'd77, eh, ed);
        n_vec++;
        if ({hit, read_data} !== {1'b0, 11'h04D}) begin
            n_miss++;
            $display("FAIL dropped_read_no_fill: hit=%0b data=%03h, want hit=0 data=04D",
                     hit, read_data);
        end
    endtask

    task automatic test_hold();
        logic eh;
        logic [10:0] ed;
        access(11'd60, eh, ed);
        access(11'd60, eh, ed);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_vec++;
            if ({hit, read_data} !== {1'b1, 11'h03C}) begin
                n_miss++;
                $display("FAIL hold[%0d]: hit=%0b data=%03h, want hit=1 data=03C",
                         i, hit, read_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic eh;
        logic [10:0] ed;
        pulse_reset(1'b0, 11'd0);
        access(11'd1234 % 2048, eh, ed);
        access(11'd1234 % 2048, eh, ed);
        n_vec++;
        if ({hit, read_data} !== {1'b1, 11'd1234}) begin
            n_miss++;
            $display("FAIL back_to_back: hit=%0b data=%03h, want hit=1 data=%03h",
                     hit, read_data, 11'd1234);
        end
    endtask

    task automatic test_random();
        logic eh;
        logic [10:0] ed;
        logic [5:0]  idx_pool [4];
        logic [10:0] a;
        for (int i = 0; i < 4; i++) idx_pool[i] = 6'($urandom);
        pulse_reset(1'b0, 11'd0);
        eh = 1'b0;
        ed = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset(1'b0, 11'd0);
                eh = 1'b0;
                ed = '0;
            end else if ($urandom_range(0, 5) == 0) begin
                idle(int'($urandom_range(1, 3)));
            end else begin
                a = {5'($urandom_range(0, 3)), idx_pool[$urandom_range(0, 3)]};
                access(a, eh, ed);
            end
            n_vec++;
            if ({hit, read_data} !== {eh, ed}) begin
                n_miss++;
                $display("FAIL random[%0d]: hit=%0b data=%03h, want hit=%0b data=%03h",
                         n, hit, read_data, eh, ed);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_cold_fill();
        test_rereference();
        test_full_trace();
        test_conflict();
        test_reset_mid_trace();
        test_reset_with_read();
        test_hold();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
